// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bundle: decode-side inputs and EX-side outputs.
// master drives the id_* side, slave (the register) drives the ex_* side.
interface id_ex_pipe_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_read_data1;
  logic [XLEN-1:0] id_read_data2;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic            id_alu_src;
  logic [3:0]      id_alu_op;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_mem_to_reg;
  logic            id_branch;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_read_data1;
  logic [XLEN-1:0]  ex_read_data2;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             ex_alu_src;
  logic [3:0]       ex_alu_op;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_mem_to_reg;
  logic             ex_branch;
  logic [CNT_W-1:0] ex_bubble_cnt;

  modport master (
    output id_valid, id_pc,
    output id_read_data1, id_read_data2,
    output id_imm, id_rs1, id_rs2, id_rd,
    output id_alu_src, id_alu_op,
    output id_reg_write, id_mem_read,
    output id_mem_write, id_mem_to_reg,
    output id_branch,
    input  ex_valid, ex_pc,
    input  ex_read_data1, ex_read_data2,
    input  ex_imm, ex_rs1, ex_rs2, ex_rd,
    input  ex_alu_src, ex_alu_op,
    input  ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_mem_to_reg,
    input  ex_branch, ex_bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc,
    input  id_read_data1, id_read_data2,
    input  id_imm, id_rs1, id_rs2, id_rd,
    input  id_alu_src, id_alu_op,
    input  id_reg_write, id_mem_read,
    input  id_mem_write, id_mem_to_reg,
    input  id_branch,
    output ex_valid, ex_pc,
    output ex_read_data1, ex_read_data2,
    output ex_imm, ex_rs1, ex_rs2, ex_rd,
    output ex_alu_src, ex_alu_op,
    output ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_mem_to_reg,
    output ex_branch, ex_bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold and flush bubble insertion.
// Define ID_EX_BUBBLE_CNT_EN to enable the saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  id_ex_pipe_reg_if.slave      bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
  } id_ex_t;

  id_ex_t d_in;
  id_ex_t d_nxt;
  id_ex_t q;
  logic   bubble;

  always_comb begin
    d_in            = '0;
    d_in.valid      = 1'b1;
    d_in.pc         = bus.id_pc;
    d_in.rd1        = bus.id_read_data1;
    d_in.rd2        = bus.id_read_data2;
    d_in.imm        = bus.id_imm;
    d_in.rs1        = bus.id_rs1;
    d_in.rs2        = bus.id_rs2;
    d_in.rd         = bus.id_rd;
    d_in.alu_src    = bus.id_alu_src;
    d_in.alu_op     = bus.id_alu_op;
    d_in.reg_write  = bus.id_reg_write;
    d_in.mem_read   = bus.id_mem_read;
    d_in.mem_write  = bus.id_mem_write;
    d_in.mem_to_reg = bus.id_mem_to_reg;
    d_in.branch     = bus.id_branch;
  end

  // flush wins over stall; an invalid decode slot loads as a bubble
  always_comb begin
    d_nxt  = q;
    bubble = 1'b0;
    priority case (1'b1)
      flush: begin
        d_nxt  = '0;
        bubble = 1'b1;
      end
      stall: begin
        d_nxt  = q;
      end
      default: begin
        if (bus.id_valid) begin
          d_nxt = d_in;
        end else begin
          d_nxt  = '0;
          bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d_nxt;
    end
  end

  assign bus.ex_valid      = q.valid;
  assign bus.ex_pc         = q.pc;
  assign bus.ex_read_data1 = q.rd1;
  assign bus.ex_read_data2 = q.rd2;
  assign bus.ex_imm        = q.imm;
  assign bus.ex_rs1        = q.rs1;
  assign bus.ex_rs2        = q.rs2;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_alu_src    = q.alu_src;
  assign bus.ex_alu_op     = q.alu_op;
  assign bus.ex_reg_write  = q.reg_write;
  assign bus.ex_mem_read   = q.mem_read;
  assign bus.ex_mem_write  = q.mem_write;
  assign bus.ex_mem_to_reg = q.mem_to_reg;
  assign bus.ex_branch     = q.branch;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt;

  // saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bubble && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.ex_bubble_cnt = cnt;
`else
  logic unused_bubble;
  assign unused_bubble     = bubble;
  assign bus.ex_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: driver queues expected EX state,
// monitor pops and compares one cycle later.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        br;
  } vec_t;

  typedef struct packed {
    vec_t       ex;
    logic [1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;

  id_ex_pipe_reg_if #(.XLEN(32), .CNT_W(2)) bus ();

  id_ex_pipe_reg #(.XLEN(32), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t act;
  always_comb begin
    act = {bus.ex_valid, bus.ex_pc, bus.ex_read_data1,
           bus.ex_read_data2, bus.ex_imm, bus.ex_rs1,
           bus.ex_rs2, bus.ex_rd, bus.ex_alu_src,
           bus.ex_alu_op, bus.ex_reg_write,
           bus.ex_mem_read, bus.ex_mem_write,
           bus.ex_mem_to_reg, bus.ex_branch};
  end

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  vec_t cur;
  logic [1:0] cnt;

  task automatic chk(string nm, vec_t e, logic [1:0] ec);
    total++;
    if (act === e) passed++;
    else $display("FAIL %s ex: got=%h expected=%h", nm, act, e);
    total++;
    if (bus.ex_bubble_cnt === ec) passed++;
    else $display("FAIL %s cnt: got=%0d expected=%0d",
                  nm, bus.ex_bubble_cnt, ec);
  endtask

  function automatic vec_t mk(logic v, logic [31:0] pc,
    logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
    logic [4:0] s1, logic [4:0] s2, logic [4:0] rd,
    logic as, logic [3:0] op, logic rw, logic mr,
    logic mw, logic mtr, logic br);
    vec_t r;
    r = {v, pc, d1, d2, imm, s1, s2, rd, as, op,
         rw, mr, mw, mtr, br};
    return r;
  endfunction

  task automatic apply(vec_t v);
    bus.id_valid      = v.valid;
    bus.id_pc         = v.pc;
    bus.id_read_data1 = v.rd1;
    bus.id_read_data2 = v.rd2;
    bus.id_imm        = v.imm;
    bus.id_rs1        = v.rs1;
    bus.id_rs2        = v.rs2;
    bus.id_rd         = v.rd;
    bus.id_alu_src    = v.alu_src;
    bus.id_alu_op     = v.alu_op;
    bus.id_reg_write  = v.rw;
    bus.id_mem_read   = v.mr;
    bus.id_mem_write  = v.mw;
    bus.id_mem_to_reg = v.mtr;
    bus.id_branch     = v.br;
  endtask

  // drive one cycle and queue the EX state expected after the next edge
  task automatic drive(vec_t v, logic st, logic fl);
    logic b;
    @(negedge clk);
    apply(v);
    stall = st;
    flush = fl;
    b = fl || (!st && !v.valid);
    if (fl) cur = '0;
    else if (!st) cur = v.valid ? v : '0;
`ifdef ID_EX_BUBBLE_CNT_EN
    if (b && cnt != 2'd3) cnt = cnt + 2'd1;
`else
    b = b & 1'b0;
`endif
    sb.push_back('{ex: cur, cnt: cnt});
  endtask

  task automatic async_reset(string nm);
    @(negedge clk);
    rst_n = 1'b0;
    cur = '0;
    cnt = '0;
    #1 chk(nm, '0, 2'd0);
    repeat (2) @(negedge clk);
    chk({nm, "_hold"}, '0, 2'd0);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("pipe", e.ex, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  vec_t v2, v3, sw_v, addi_v, bad_v, z;

  initial begin : stim
    z = '0;
    cur = '0;
    cnt = '0;
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    apply(z);
    repeat (2) @(negedge clk);
    chk("reset_state", '0, 2'd0);
    rst_n = 1'b1;

    v2 = mk(1, 32'h100, 32'h11, 32'h0000_00AA, 32'hFFFF_FFF0,
            5'd1, 5'd2, 5'd5, 1, 4'h0, 1, 0, 0, 0, 0);
    drive(v2, 0, 0);

    // EX holds a live reg_write instruction when reset hits
    @(negedge clk);
    total++;
    if (bus.ex_valid === 1'b1 && bus.ex_reg_write === 1'b1
        && bus.ex_imm === 32'hFFFF_FFF0 && bus.ex_rd === 5'd5)
      passed++;
    else
      $display("FAIL pre_reset: got=%b%b expected=11",
               bus.ex_valid, bus.ex_reg_write);
    async_reset("mid_reset");

    v3 = mk(1, 32'h104, 32'h1, 32'h2, 32'h3,
            5'd3, 5'd4, 5'd6, 0, 4'h1, 1, 0, 0, 0, 0);
    drive(v3, 0, 0);

    for (int i = 0; i < 3; i++)
      drive(mk(1, 32'h200 + i, 32'hA0 + i, 32'hB0 + i,
               32'hC0 + i, 5'd7, 5'd8, 5'd9, 1, 4'h2,
               1, 1, 1, 1, 1), 1, 0);
    drive(mk(1, 32'h210, 32'hDEAD, 32'hBEEF, 32'h7,
             5'd10, 5'd11, 5'd12, 1, 4'h3, 1, 1, 0, 1, 0), 0, 0);

    sw_v = mk(1, 32'h300, 32'h1000, 32'h55, 32'h8,
              5'd2, 5'd13, 5'd0, 1, 4'h0, 0, 0, 1, 0, 0);
    drive(sw_v, 0, 0);
    drive(mk(1, 32'h304, 32'h9, 32'h9, 32'h9,
             5'd1, 5'd1, 5'd1, 1, 4'h4, 1, 0, 1, 0, 0), 1, 1);

    addi_v = mk(1, 32'h308, 32'h20, 32'h0, 32'hFFFF_FFFF,
                5'd14, 5'd0, 5'd15, 1, 4'h0, 1, 0, 0, 0, 0);
    drive(sw_v, 0, 0);
    drive(addi_v, 0, 0);

    bad_v = mk(0, 32'h400, 32'h1, 32'h2, 32'h3,
               5'd1, 5'd2, 5'd3, 1, 4'hF, 1, 1, 1, 1, 1);
    drive(bad_v, 0, 0);
    drive(addi_v, 0, 0);
    drive(bad_v, 1, 0);

    async_reset("cnt_reset");
    for (int i = 0; i < 5; i++)
      drive(mk(1, 32'h500 + 4 * i, 32'h1, 32'h2, 32'h3,
               5'd1, 5'd2, 5'd3, 0, 4'h5, 1, 0, 1, 0, 1), 0, 1);
    drive(addi_v, 1, 0);
    drive(sw_v, 1, 0);
    drive(sw_v, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
